// File: rtl/midi_uart_tx.sv
// MIDI serial transmitter: pops bytes from a standard (non-FWFT) FIFO and sends 8N1 frames.
// Optionally inserts Active Sensing (0xFE) after a configurable idle time.
module midi_uart_tx #(
    parameter int CLK_FREQ     = 100000000,
    parameter int BAUD         = 31250,
    parameter int SENSE_EN     = 0,
    parameter int SENSE_CYCLES = 30000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_dout,
    output logic       fifo_rd_en,
    output logic       tx,
    output logic       busy
);

    localparam int DIV = CLK_FREQ / BAUD;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SW  = (SENSE_CYCLES > 1) ? $clog2(SENSE_CYCLES) : 1;

    if (DIV < 2) begin : g_div_check
        $fatal(1, "midi_uart_tx: CLK_FREQ/BAUD must be at least 2");
    end

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        START = 3'd2,
        DATA  = 3'd3,
        STOP  = 3'd4
    } state_t;

    state_t          state;
    logic [CW-1:0]   baud_cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shreg;
    logic            sense_hit;
    logic            baud_end;

    assign baud_end = (baud_cnt == CW'(DIV - 1));

    // The pop strobe must land in the same cycle as the IDLE decision, so it is
    // decoded from the registered state rather than registered itself.
    assign fifo_rd_en = rst && (state == IDLE) && !fifo_empty;
    assign busy       = (state != IDLE) || fifo_rd_en;

    if (SENSE_EN != 0) begin : g_sense
        logic [SW-1:0] idle_cnt;

        assign sense_hit = (state == IDLE) && fifo_empty && (idle_cnt == SW'(SENSE_CYCLES - 1));

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                idle_cnt <= '0;
            end else if ((state == IDLE) && fifo_empty && !sense_hit) begin
                idle_cnt <= idle_cnt + SW'(1);
            end else begin
                idle_cnt <= '0;
            end
        end
    end else begin : g_no_sense
        assign sense_hit = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            tx       <= 1'b1;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    tx       <= 1'b1;
                    baud_cnt <= '0;
                    bit_idx  <= '0;
                    // A waiting FIFO byte always beats the sense timeout.
                    if (!fifo_empty) begin
                        state <= FETCH;
                    end else if (sense_hit) begin
                        shreg <= 8'hFE;
                        tx    <= 1'b0;
                        state <= START;
                    end
                end
                FETCH: begin
                    shreg    <= fifo_dout;
                    tx       <= 1'b0;
                    baud_cnt <= '0;
                    state    <= START;
                end
                START: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        tx       <= shreg[0];
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            tx    <= 1'b1;
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            shreg   <= {1'b0, shreg[7:1]};
                            tx      <= shreg[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CW'(1);
                    end
                end
                STOP: begin
                    tx <= 1'b1;
                    if (baud_end) begin
                        baud_cnt <= '0;
                        state    <= IDLE;
                    end else begin
                        baud_cnt <= baud_cnt + CW'(1);
                    end
                end
                default: begin
                    tx       <= 1'b1;
                    baud_cnt <= '0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_midi_uart_tx.sv
// Directed bench for midi_uart_tx at DIV=32: one plain instance and one with Active Sensing.
module tb_midi_uart_tx;

    logic       clk;
    logic       rst0, rst1;
    logic       fe0, fe1;
    logic [7:0] dout0, dout1;
    logic       rd_en0, rd_en1;
    logic       tx0, tx1;
    logic       busy0, busy1;

    logic [7:0] mem0 [0:15];
    logic [7:0] mem1 [0:15];
    logic [3:0] wp0, rp0, wp1, rp1;

    int checks;
    int errors;
    int rd_cnt0, rd_cnt1, busy_cnt0;

    midi_uart_tx #(
        .CLK_FREQ(1000000), .BAUD(31250), .SENSE_EN(0), .SENSE_CYCLES(1000)
    ) u_dut0 (
        .clk(clk), .rst(rst0), .fifo_empty(fe0), .fifo_dout(dout0),
        .fifo_rd_en(rd_en0), .tx(tx0), .busy(busy0)
    );

    midi_uart_tx #(
        .CLK_FREQ(1000000), .BAUD(31250), .SENSE_EN(1), .SENSE_CYCLES(1000)
    ) u_dut1 (
        .clk(clk), .rst(rst1), .fifo_empty(fe1), .fifo_dout(dout1),
        .fifo_rd_en(rd_en1), .tx(tx1), .busy(busy1)
    );

    // clock / FIFO models / monitors
    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign fe0 = (wp0 == rp0);
    assign fe1 = (wp1 == rp1);

    initial begin
        rp0 = '0;
        rp1 = '0;
        dout0 = '0;
        dout1 = '0;
    end

    always @(posedge clk) begin
        if (rd_en0) begin
            dout0 <= mem0[rp0];
            rp0   <= rp0 + 4'd1;
        end
        if (rd_en1) begin
            dout1 <= mem1[rp1];
            rp1   <= rp1 + 4'd1;
        end
    end

    initial begin
        rd_cnt0 = 0;
        rd_cnt1 = 0;
        busy_cnt0 = 0;
    end

    always @(negedge clk) begin
        if (rd_en0) rd_cnt0 <= rd_cnt0 + 1;
        if (rd_en1) rd_cnt1 <= rd_cnt1 + 1;
        if (busy0)  busy_cnt0 <= busy_cnt0 + 1;
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push0(input logic [7:0] b);
        mem0[wp0] = b;
        wp0 = wp0 + 4'd1;
    endtask

    task automatic push1(input logic [7:0] b);
        mem1[wp1] = b;
        wp1 = wp1 + 4'd1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_fall(input int sel, input int maxc, output int n);
        logic t;
        n = -1;
        for (int i = 1; i <= maxc; i++) begin
            step();
            t = (sel == 0) ? tx0 : tx1;
            if (t == 1'b0) begin
                n = i;
                break;
            end
        end
    endtask

    // Called in the first START cycle; ends in the last STOP cycle.
    task automatic check_frame(input int sel, input logic [7:0] b, input string tag);
        int   bad;
        int   first_bad;
        logic exp;
        logic t, bz;
        bad = 0;
        first_bad = -1;
        for (int c = 0; c < 320; c++) begin
            if (c > 0) step();
            if (c < 32)       exp = 1'b0;
            else if (c < 288) exp = b[(c - 32) / 32];
            else              exp = 1'b1;
            t  = (sel == 0) ? tx0 : tx1;
            bz = (sel == 0) ? busy0 : busy1;
            if (t !== exp || bz !== 1'b1) begin
                bad++;
                if (first_bad < 0) first_bad = c;
            end
        end
        chk(tag, bad, 0);
        if (bad != 0) $display("  %s first bad frame cycle %0d", tag, first_bad);
    endtask

    // directed sequence
    initial begin
        int n;
        int rc_snap, bc_snap;
        int bad;
        checks = 0;
        errors = 0;
        wp0 = '0;
        wp1 = '0;
        rst0 = 1'b0;
        rst1 = 1'b0;
        repeat (3) step();

        chk("reset_tx0", tx0, 1);
        chk("reset_busy0", busy0, 0);
        chk("reset_rd_en0", rd_en0, 0);
        chk("reset_tx1", tx1, 1);
        chk("reset_busy1", busy1, 0);

        // byte waiting during reset must not be popped until release
        push0(8'h90);
        #1;
        chk("rd_en_in_reset", rd_en0, 0);
        chk("busy_in_reset", busy0, 0);
        rc_snap = rd_cnt0;
        bc_snap = busy_cnt0;
        step();
        rst0 = 1'b1;
        #1;
        chk("rd_en_after_release", rd_en0, 1);
        wait_fall(0, 10, n);
        chk("single_rd_to_fall", n, 2);
        check_frame(0, 8'h90, "single_frame_90");
        repeat (5) step();
        chk("single_idle_busy", busy0, 0);
        chk("single_rd_pulses", rd_cnt0 - rc_snap, 1);
        chk("single_busy_cycles", busy_cnt0 - bc_snap, 322);

        // back-to-back frames
        rc_snap = rd_cnt0;
        push0(8'h90);
        push0(8'h3C);
        push0(8'h7F);
        wait_fall(0, 10, n);
        chk("b2b_first_fall", n, 2);
        check_frame(0, 8'h90, "b2b_frame_90");
        wait_fall(0, 10, n);
        chk("b2b_gap_1", n, 3);
        check_frame(0, 8'h3C, "b2b_frame_3c");
        wait_fall(0, 10, n);
        chk("b2b_gap_2", n, 3);
        check_frame(0, 8'h7F, "b2b_frame_7f");
        step();
        chk("b2b_end_busy", busy0, 0);
        chk("b2b_end_rd_en", rd_en0, 0);
        repeat (50) step();
        chk("b2b_rd_pulses", rd_cnt0 - rc_snap, 3);
        chk("b2b_tx_idle", tx0, 1);

        // reset while tx is low in START must raise tx at once
        push0(8'h55);
        wait_fall(0, 10, n);
        chk("start_rst_fall", n, 2);
        repeat (5) step();
        chk("start_rst_pre_tx", tx0, 0);
        rst0 = 1'b0;
        #1;
        chk("start_rst_tx", tx0, 1);
        chk("start_rst_busy", busy0, 0);
        step();
        rst0 = 1'b1;

        // reset in bit 3 of 0xAA
        step();
        push0(8'hAA);
        wait_fall(0, 10, n);
        chk("data_rst_fall", n, 2);
        repeat (138) step();
        chk("data_rst_bit3", tx0, 1);
        rst0 = 1'b0;
        #1;
        chk("data_rst_tx", tx0, 1);
        chk("data_rst_busy", busy0, 0);
        chk("data_rst_rd_en", rd_en0, 0);
        repeat (3) step();
        rst0 = 1'b1;
        rc_snap = rd_cnt0;
        bad = 0;
        for (int i = 0; i < 400; i++) begin
            step();
            if (tx0 !== 1'b1 || busy0 !== 1'b0 || rd_en0 !== 1'b0) bad++;
        end
        chk("post_rst_quiet", bad, 0);
        chk("post_rst_rd_pulses", rd_cnt0 - rc_snap, 0);

        // Active Sensing on the second instance
        step();
        rst1 = 1'b1;
        wait_fall(1, 1100, n);
        chk("sense_first_delay", n, 1000);
        chk("sense_no_rd_en", rd_cnt1, 0);
        check_frame(1, 8'hFE, "sense_frame_1");
        wait_fall(1, 1100, n);
        chk("sense_period", n, 1001);
        check_frame(1, 8'hFE, "sense_frame_2");
        step();
        chk("sense_idle_busy", busy1, 0);

        // FIFO byte arriving in the timeout cycle wins
        repeat (999) step();
        push1(8'h80);
        #1;
        chk("collide_rd_en", rd_en1, 1);
        wait_fall(1, 10, n);
        chk("collide_fall", n, 2);
        check_frame(1, 8'h80, "collide_frame_80");
        wait_fall(1, 1100, n);
        chk("collide_restart", n, 1001);
        check_frame(1, 8'hFE, "sense_frame_3");
        chk("sense_rd_pulses", rd_cnt1, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
